// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - pixel/control bundle between sprite generators, game_ctrl and VGA output
// Members:
//   refresh_tick  frame-start pulse              video_on  visible-area flag
//   start_key     debounced start level          car_on/car_rgb  player-car pixel
//   obs_on/obs_rgb  obstacle pixel               pause     freeze sprite motion
//   game_rst      one-cycle sprite restart       score     4-digit BCD score
//   lives         remaining lives                state     00 IDLE 01 PLAY 10 CRASH 11 OVER
//   rgb           registered pixel colour
// master drives the pixel/key inputs, slave (game_ctrl) drives the game outputs.
interface game_ctrl_if;
    logic        refresh_tick;
    logic        video_on;
    logic        start_key;
    logic        car_on;
    logic [11:0] car_rgb;
    logic        obs_on;
    logic [11:0] obs_rgb;
    logic        pause;
    logic        game_rst;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic [11:0] rgb;

    modport master (
        output refresh_tick, video_on, start_key, car_on, car_rgb, obs_on, obs_rgb,
        input  pause, game_rst, score, lives, state, rgb
    );

    modport slave (
        input  refresh_tick, video_on, start_key, car_on, car_rgb, obs_on, obs_rgb,
        output pause, game_rst, score, lives, state, rgb
    );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - collision detect, game FSM, BCD score/lives and RGB priority mux
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   gif    game_ctrl_if.slave (pixel inputs, start key, game outputs, rgb)
module game_ctrl #(
    parameter int          LIVES_INIT   = 3,
    parameter int          SCORE_DIV    = 30,
    parameter int          CRASH_FRAMES = 90,
    parameter int          FLASH_BIT    = 3,
    parameter logic [11:0] ROAD_RGB     = 12'h444
) (
    input  logic        clk,
    input  logic        reset,
    game_ctrl_if.slave  gif
);
    localparam int DW = $clog2(SCORE_DIV + 1);
    localparam int CW = $clog2(CRASH_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        CRASH = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t          st;
    logic            pause_q;
    logic            game_rst_q;
    logic [15:0]     score_q;
    logic [2:0]      lives_q;
    logic [11:0]     rgb_q;
    logic            start_q;
    logic            hit_flag;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   crash_cnt;

    logic start_rise;
    logic hit_cond;
    logic hit_seen;

    assign start_rise = gif.start_key & ~start_q;
    assign hit_cond   = gif.car_on & gif.obs_on & gif.video_on;
    // A collision on the refresh cycle itself belongs to the frame being closed.
    assign hit_seen   = hit_flag | hit_cond;

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            pause_q    <= 1'b1;
            game_rst_q <= 1'b0;
            score_q    <= '0;
            lives_q    <= 3'(LIVES_INIT);
            rgb_q      <= '0;
            start_q    <= 1'b0;
            hit_flag   <= 1'b0;
            div_cnt    <= '0;
            crash_cnt  <= '0;
        end else begin
            start_q    <= gif.start_key;
            hit_flag   <= gif.refresh_tick ? 1'b0 : (hit_flag | hit_cond);
            game_rst_q <= 1'b0;

            case (st)
                IDLE: begin
                    if (start_rise) begin
                        st         <= PLAY;
                        pause_q    <= 1'b0;
                        game_rst_q <= 1'b1;
                        lives_q    <= 3'(LIVES_INIT);
                        score_q    <= '0;
                        div_cnt    <= '0;
                    end
                end
                PLAY: begin
                    if (gif.refresh_tick) begin
                        if (hit_seen) begin
                            // The hit is taken first; that frame earns no score.
                            if (lives_q <= 3'd1) begin
                                st      <= OVER;
                                lives_q <= 3'd0;
                            end else begin
                                st        <= CRASH;
                                lives_q   <= lives_q - 3'd1;
                                crash_cnt <= '0;
                            end
                            pause_q <= 1'b1;
                        end else if (div_cnt == DW'(SCORE_DIV - 1)) begin
                            div_cnt <= '0;
                            score_q <= bcd_inc(score_q);
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                CRASH: begin
                    if (gif.refresh_tick) begin
                        if (crash_cnt == CW'(CRASH_FRAMES - 1)) begin
                            st         <= PLAY;
                            pause_q    <= 1'b0;
                            game_rst_q <= 1'b1;
                        end else begin
                            crash_cnt <= crash_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        st         <= IDLE;
                        pause_q    <= 1'b1;
                        game_rst_q <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase

            if (!gif.video_on) begin
                rgb_q <= '0;
            end else if (gif.car_on) begin
                rgb_q <= (st == CRASH && crash_cnt[FLASH_BIT]) ? ~gif.car_rgb : gif.car_rgb;
            end else if (gif.obs_on) begin
                rgb_q <= gif.obs_rgb;
            end else begin
                rgb_q <= ROAD_RGB;
            end
        end
    end

    assign gif.state    = st;
    assign gif.pause    = pause_q;
    assign gif.game_rst = game_rst_q;
    assign gif.score    = score_q;
    assign gif.lives    = lives_q;
    assign gif.rgb      = rgb_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl
module tb_game_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_ctrl_if ifa ();
    game_ctrl_if ifb ();

    game_ctrl dut (.clk(clk), .reset(reset), .gif(ifa));
    game_ctrl #(.SCORE_DIV(1)) dutb (.clk(clk), .reset(reset), .gif(ifb));

    typedef struct {
        logic [1:0]  st;
        logic        pause;
        logic        rst;
        logic [15:0] score;
        logic [2:0]  lives;
    } exp_t;

    typedef struct {
        int          due;
        logic [11:0] val;
    } rgb_exp_t;

    exp_t     eq[$];
    rgb_exp_t rq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int req = 0;
    logic mon_en = 1'b0;
    logic b_en = 1'b0;
    int b_cnt = 0;
    logic [1:0]  p_state = 2'b00;
    logic [15:0] p_score = 16'h0000;
    logic [2:0]  p_lives = 3'd3;
    logic [15:0] pb_score = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    // Single checking process: every comparison and counter update happens here.
    always @(negedge clk) begin
        exp_t     e;
        rgb_exp_t r;
        logic [15:0] eb;
        if (mon_en) begin
            if (ifa.state != p_state || ifa.score != p_score || ifa.lives != p_lives || ifa.game_rst) begin
                n_vec++;
                if (eq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event cyc=%0d: got state=%b score=%h lives=%0d game_rst=%b, expected no event",
                             cyc, ifa.state, ifa.score, ifa.lives, ifa.game_rst);
                end else begin
                    e = eq.pop_front();
                    if (ifa.state !== e.st || ifa.pause !== e.pause || ifa.game_rst !== e.rst ||
                        ifa.score !== e.score || ifa.lives !== e.lives) begin
                        n_err++;
                        $display("FAIL event cyc=%0d: got st=%b pause=%b rst=%b score=%h lives=%0d, expected st=%b pause=%b rst=%b score=%h lives=%0d",
                                 cyc, ifa.state, ifa.pause, ifa.game_rst, ifa.score, ifa.lives,
                                 e.st, e.pause, e.rst, e.score, e.lives);
                    end
                end
            end
            p_state = ifa.state;
            p_score = ifa.score;
            p_lives = ifa.lives;

            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                n_vec++;
                if (r.due != cyc || ifa.rgb !== r.val) begin
                    n_err++;
                    $display("FAIL rgb cyc=%0d due=%0d: got %h, expected %h", cyc, r.due, ifa.rgb, r.val);
                end
            end
        end

        if (b_en && ifb.score != pb_score) begin
            n_vec++;
            if (b_cnt >= 9999) begin
                n_err++;
                $display("FAIL b_saturate: got %h, expected 9999 held", ifb.score);
            end else begin
                b_cnt++;
                eb = to_bcd(b_cnt);
                if (ifb.score !== eb) begin
                    n_err++;
                    $display("FAIL b_score step %0d: got %h, expected %h", b_cnt, ifb.score, eb);
                end
            end
        end
        pb_score = ifb.score;

        case (req)
            1: begin
                n_vec++;
                if (ifa.state !== 2'b00 || ifa.pause !== 1'b1 || ifa.game_rst !== 1'b0 ||
                    ifa.score !== 16'h0000 || ifa.lives !== 3'd3 || ifa.rgb !== 12'h000) begin
                    n_err++;
                    $display("FAIL reset_state: got st=%b pause=%b rst=%b score=%h lives=%0d rgb=%h, expected 00 1 0 0000 3 000",
                             ifa.state, ifa.pause, ifa.game_rst, ifa.score, ifa.lives, ifa.rgb);
                end
            end
            2: begin
                n_vec++;
                if (ifb.score !== 16'h9999 || ifb.state !== 2'b01 || ifb.pause !== 1'b0) begin
                    n_err++;
                    $display("FAIL b_final: got score=%h st=%b pause=%b, expected 9999 01 0",
                             ifb.score, ifb.state, ifb.pause);
                end
                n_vec++;
                if (b_cnt != 9999) begin
                    n_err++;
                    $display("FAIL b_steps: got %0d increments, expected 9999", b_cnt);
                end
            end
            3: begin
                n_vec++;
                if (eq.size() != 0 || rq.size() != 0) begin
                    n_err++;
                    $display("FAIL pending: got %0d events and %0d rgb checks outstanding, expected 0",
                             eq.size(), rq.size());
                end
            end
            default: ;
        endcase
    end

    task automatic snapshot(input int code);
        @(posedge clk);
        #1 req = code;
        @(negedge clk);
        #1 req = 0;
    endtask

    task automatic push_ev(input logic [1:0] st, input logic pz, input logic rs,
                           input logic [15:0] sc, input logic [2:0] lv);
        exp_t e;
        e.st = st; e.pause = pz; e.rst = rs; e.score = sc; e.lives = lv;
        eq.push_back(e);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ifa.refresh_tick = 1'b1;
            @(negedge clk);
            ifa.refresh_tick = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic overlap(input logic vis);
        @(negedge clk);
        ifa.car_on = 1'b1; ifa.obs_on = 1'b1; ifa.video_on = vis;
        @(negedge clk);
        ifa.car_on = 1'b0; ifa.obs_on = 1'b0; ifa.video_on = 1'b0;
    endtask

    task automatic pix(input logic vis, input logic car, input logic obs, input logic [11:0] ev);
        rgb_exp_t r;
        @(negedge clk);
        ifa.video_on = vis; ifa.car_on = car; ifa.obs_on = obs;
        r.due = cyc + 1;
        r.val = ev;
        rq.push_back(r);
        @(negedge clk);
        ifa.car_on = 1'b0; ifa.obs_on = 1'b0; ifa.video_on = 1'b0;
    endtask

    task automatic press(input int n);
        @(negedge clk);
        ifa.start_key = 1'b1;
        repeat (n) @(negedge clk);
        ifa.start_key = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifa.refresh_tick = 1'b0; ifa.video_on = 1'b0; ifa.start_key = 1'b0;
        ifa.car_on = 1'b0; ifa.obs_on = 1'b0; ifa.car_rgb = 12'h0F0; ifa.obs_rgb = 12'hF00;
        ifb.refresh_tick = 1'b0; ifb.video_on = 1'b0; ifb.start_key = 1'b0;
        ifb.car_on = 1'b0; ifb.obs_on = 1'b0; ifb.car_rgb = 12'h000; ifb.obs_rgb = 12'h000;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        snapshot(1);
        mon_en = 1'b1;

        // Idle: RGB priority, no events over 5 frames.
        pix(1'b1, 1'b0, 1'b1, 12'hF00);
        pix(1'b1, 1'b0, 1'b0, 12'h444);
        pix(1'b0, 1'b0, 1'b1, 12'h000);
        pix(1'b1, 1'b1, 1'b1, 12'h0F0);
        frames(5);

        // Start, held key gives one edge.
        push_ev(2'b01, 1'b0, 1'b1, 16'h0000, 3'd3);
        press(10);
        pix(1'b1, 1'b1, 1'b0, 12'h0F0);

        // 60 clean frames: score 1 then 2.
        push_ev(2'b01, 1'b0, 1'b0, 16'h0001, 3'd3);
        push_ev(2'b01, 1'b0, 1'b0, 16'h0002, 3'd3);
        frames(60);

        // Overlap outside the visible area is not a hit.
        overlap(1'b0);
        frames(1);

        // Hit 1 -> CRASH, lives 2.
        push_ev(2'b10, 1'b1, 1'b0, 16'h0002, 3'd2);
        overlap(1'b1);
        frames(1);
        pix(1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(1'b0, 1'b1, 1'b1, 12'h000);
        pix(1'b1, 1'b0, 1'b1, 12'hF00);
        pix(1'b1, 1'b0, 1'b0, 12'h444);
        frames(8);
        pix(1'b1, 1'b1, 1'b1, 12'hF0F);
        pix(1'b1, 1'b1, 1'b0, 12'hF0F);
        push_ev(2'b01, 1'b0, 1'b1, 16'h0002, 3'd2);
        frames(82);

        // Hit 2 -> CRASH, lives 1, resume after 90 frames.
        push_ev(2'b10, 1'b1, 1'b0, 16'h0002, 3'd1);
        overlap(1'b1);
        frames(1);
        push_ev(2'b01, 1'b0, 1'b1, 16'h0002, 3'd1);
        frames(90);

        // Hit 3 -> OVER, lives 0, held.
        push_ev(2'b11, 1'b1, 1'b0, 16'h0002, 3'd0);
        overlap(1'b1);
        frames(1);
        frames(3);

        // OVER -> IDLE, then IDLE -> PLAY with fresh score/lives.
        push_ev(2'b00, 1'b1, 1'b1, 16'h0002, 3'd0);
        press(5);
        repeat (3) @(negedge clk);
        push_ev(2'b01, 1'b0, 1'b1, 16'h0000, 3'd3);
        press(1);
        repeat (3) @(negedge clk);

        // Hit coincident with refresh_tick counts for that frame.
        push_ev(2'b10, 1'b1, 1'b0, 16'h0000, 3'd2);
        @(negedge clk);
        ifa.refresh_tick = 1'b1; ifa.car_on = 1'b1; ifa.obs_on = 1'b1; ifa.video_on = 1'b1;
        @(negedge clk);
        ifa.refresh_tick = 1'b0; ifa.car_on = 1'b0; ifa.obs_on = 1'b0; ifa.video_on = 1'b0;
        repeat (5) @(negedge clk);

        // Score saturation on a SCORE_DIV=1 instance: one increment per tick.
        b_en = 1'b1;
        @(negedge clk);
        ifb.refresh_tick = 1'b1;
        ifb.start_key = 1'b1;
        @(negedge clk);
        ifb.start_key = 1'b0;
        repeat (10050) @(negedge clk);
        snapshot(2);

        snapshot(3);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
